// File: rtl/core_alu_signals.sv
// Shared definitions for the CPU core ALU: operation codes and processor-status bit positions.
package core_alu_signals;

  typedef enum logic [4:0] {
    control_nop = 5'd0,
    control_ora = 5'd1,
    control_and = 5'd2,
    control_eor = 5'd3,
    control_adc = 5'd4,
    control_sbc = 5'd5,
    control_cmp = 5'd6,
    control_bit = 5'd7,
    control_asl = 5'd8,
    control_lsr = 5'd9,
    control_rol = 5'd10,
    control_ror = 5'd11,
    control_inc = 5'd12,
    control_dec = 5'd13,
    control_mov = 5'd14,
    control_clc = 5'd15,
    control_sec = 5'd16,
    control_clv = 5'd17
  } control_type;

  // Bit positions inside the processor status byte.
  localparam int C = 0;
  localparam int Z = 1;
  localparam int I = 2;
  localparam int D = 3;
  localparam int B = 4;
  localparam int X = 5;
  localparam int V = 6;
  localparam int N = 7;

  function automatic logic [7:0] set_nz(input logic [7:0] flags, input logic [7:0] value);
    logic [7:0] f;
    f    = flags;
    f[N] = value[7];
    f[Z] = (value == 8'h00);
    return f;
  endfunction

endpackage

// File: rtl/core_alu_comb.sv
// Combinational operation mux and flag logic of the ALU; no state.
module core_alu_comb
  import core_alu_signals::*;
(
  input  control_type control_i,
  input  logic        mask_p_i,
  input  logic [7:0]  lhs_i,
  input  logic [7:0]  rhs_i,
  input  logic        carry_i,
  input  logic        overflow_i,
  input  logic        sign_i,
  input  logic        zero_i,
  output logic [7:0]  result_o,
  output logic        carry_o,
  output logic        overflow_o,
  output logic        sign_o,
  output logic        zero_o
);

  logic [7:0] flags_in;
  logic [7:0] flags_op;
  logic [8:0] sum_adc;
  logic [8:0] sum_sbc;
  logic [8:0] diff_cmp;

  // Only C, Z, V and N are meaningful here; the other status bits stay 0.
  assign flags_in = {sign_i, overflow_i, 4'b0000, zero_i, carry_i};

  assign sum_adc  = {1'b0, lhs_i} + {1'b0, rhs_i}  + {8'b0, carry_i};
  assign sum_sbc  = {1'b0, lhs_i} + {1'b0, ~rhs_i} + {8'b0, carry_i};
  assign diff_cmp = {1'b0, lhs_i} + {1'b0, ~rhs_i} + 9'd1;

  always_comb begin
    result_o = lhs_i;
    flags_op = flags_in;
    case (control_i)
      control_ora: begin
        result_o = lhs_i | rhs_i;
        flags_op = set_nz(flags_in, result_o);
      end
      control_and: begin
        result_o = lhs_i & rhs_i;
        flags_op = set_nz(flags_in, result_o);
      end
      control_eor: begin
        result_o = lhs_i ^ rhs_i;
        flags_op = set_nz(flags_in, result_o);
      end
      control_adc: begin
        result_o    = sum_adc[7:0];
        flags_op    = set_nz(flags_in, sum_adc[7:0]);
        flags_op[C] = sum_adc[8];
        flags_op[V] = (lhs_i[7] == rhs_i[7]) && (sum_adc[7] != lhs_i[7]);
      end
      control_sbc: begin
        // Subtraction is addition of the inverted operand; C=1 means no borrow.
        result_o    = sum_sbc[7:0];
        flags_op    = set_nz(flags_in, sum_sbc[7:0]);
        flags_op[C] = sum_sbc[8];
        flags_op[V] = (lhs_i[7] == ~rhs_i[7]) && (sum_sbc[7] != lhs_i[7]);
      end
      control_cmp: begin
        flags_op    = set_nz(flags_in, diff_cmp[7:0]);
        flags_op[C] = diff_cmp[8];
      end
      control_bit: begin
        flags_op[Z] = ((lhs_i & rhs_i) == 8'h00);
        flags_op[N] = rhs_i[7];
        flags_op[V] = rhs_i[6];
      end
      control_asl: begin
        result_o    = {lhs_i[6:0], 1'b0};
        flags_op    = set_nz(flags_in, result_o);
        flags_op[C] = lhs_i[7];
      end
      control_lsr: begin
        result_o    = {1'b0, lhs_i[7:1]};
        flags_op    = set_nz(flags_in, result_o);
        flags_op[C] = lhs_i[0];
      end
      control_rol: begin
        result_o    = {lhs_i[6:0], carry_i};
        flags_op    = set_nz(flags_in, result_o);
        flags_op[C] = lhs_i[7];
      end
      control_ror: begin
        result_o    = {carry_i, lhs_i[7:1]};
        flags_op    = set_nz(flags_in, result_o);
        flags_op[C] = lhs_i[0];
      end
      control_inc: begin
        result_o = lhs_i + 8'd1;
        flags_op = set_nz(flags_in, result_o);
      end
      control_dec: begin
        result_o = lhs_i - 8'd1;
        flags_op = set_nz(flags_in, result_o);
      end
      control_mov: begin
        result_o = rhs_i;
        flags_op = set_nz(flags_in, result_o);
      end
      control_clc: flags_op[C] = 1'b0;
      control_sec: flags_op[C] = 1'b1;
      control_clv: flags_op[V] = 1'b0;
      // nop and the reserved codes leave everything as defaulted above.
      default: ;
    endcase
  end

  always_comb begin
    carry_o    = carry_i;
    overflow_o = overflow_i;
    sign_o     = sign_i;
    zero_o     = zero_i;
    if (mask_p_i) begin
      carry_o    = flags_op[C];
      overflow_o = flags_op[V];
      sign_o     = flags_op[N];
      zero_o     = flags_op[Z];
    end
  end

endmodule

// File: rtl/core_alu_unit.sv
// Registered ALU: captures the combinational result and flags on each enabled rising edge.
module core_alu_unit
  import core_alu_signals::*;
(
  input  logic        I_clock,
  input  logic        I_reset,
  input  logic        I_enable,
  input  control_type I_control,
  input  logic        I_mask_p,
  input  logic [7:0]  I_lhs,
  input  logic [7:0]  I_rhs,
  input  logic        I_carry,
  input  logic        I_overflow,
  input  logic        I_sign,
  input  logic        I_zero,
  output logic [7:0]  O_result,
  output logic        O_carry,
  output logic        O_overflow,
  output logic        O_sign,
  output logic        O_zero
);

  logic [7:0] result_d, result_q;
  logic       carry_d, carry_q;
  logic       overflow_d, overflow_q;
  logic       sign_d, sign_q;
  logic       zero_d, zero_q;

  core_alu_comb u_comb (
    .control_i  (I_control),
    .mask_p_i   (I_mask_p),
    .lhs_i      (I_lhs),
    .rhs_i      (I_rhs),
    .carry_i    (I_carry),
    .overflow_i (I_overflow),
    .sign_i     (I_sign),
    .zero_i     (I_zero),
    .result_o   (result_d),
    .carry_o    (carry_d),
    .overflow_o (overflow_d),
    .sign_o     (sign_d),
    .zero_o     (zero_d)
  );

  // Reset wins over enable; with enable low the stage simply holds.
  always_ff @(posedge I_clock) begin
    if (I_reset) begin
      result_q   <= 8'h00;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
      sign_q     <= 1'b0;
      zero_q     <= 1'b0;
    end else if (I_enable) begin
      result_q   <= result_d;
      carry_q    <= carry_d;
      overflow_q <= overflow_d;
      sign_q     <= sign_d;
      zero_q     <= zero_d;
    end
  end

  assign O_result   = result_q;
  assign O_carry    = carry_q;
  assign O_overflow = overflow_q;
  assign O_sign     = sign_q;
  assign O_zero     = zero_q;

endmodule

// File: tb/tb_core_alu_unit.sv
// Bench for core_alu_unit: directed cases with literal expectations plus randomized traffic
// scored against an integer-arithmetic reference model.
module tb_core_alu_unit;
  import core_alu_signals::*;

  logic        I_clock;
  logic        I_reset;
  logic        I_enable;
  control_type I_control;
  logic        I_mask_p;
  logic [7:0]  I_lhs;
  logic [7:0]  I_rhs;
  logic        I_carry;
  logic        I_overflow;
  logic        I_sign;
  logic        I_zero;
  logic [7:0]  O_result;
  logic        O_carry;
  logic        O_overflow;
  logic        O_sign;
  logic        O_zero;

  core_alu_unit dut (
    .I_clock    (I_clock),
    .I_reset    (I_reset),
    .I_enable   (I_enable),
    .I_control  (I_control),
    .I_mask_p   (I_mask_p),
    .I_lhs      (I_lhs),
    .I_rhs      (I_rhs),
    .I_carry    (I_carry),
    .I_overflow (I_overflow),
    .I_sign     (I_sign),
    .I_zero     (I_zero),
    .O_result   (O_result),
    .O_carry    (O_carry),
    .O_overflow (O_overflow),
    .O_sign     (O_sign),
    .O_zero     (O_zero)
  );

  // ---------------- clock / reset ----------------
  initial begin
    I_clock = 1'b0;
    forever #5 I_clock = ~I_clock;
  end

  // ---------------- scoreboard ----------------
  // Tuple layout: {result[7:0], N, V, Z, C}
  logic [11:0] exp_q[$];
  logic [11:0] exp_state;
  int n_checks;
  int n_passed;

  task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
    n_checks++;
    if (got === exp) n_passed++;
    else $display("FAIL %s: got res=%02h nvzc=%04b, expected res=%02h nvzc=%04b",
                  tag, got[11:4], got[3:0], exp[11:4], exp[3:0]);
  endtask

  function automatic logic [11:0] observed();
    return {O_result, O_sign, O_overflow, O_zero, O_carry};
  endfunction

  // ---------------- reference model ----------------
  function automatic int sx(input int v);
    return (v > 127) ? v - 256 : v;
  endfunction

  function automatic logic [11:0] model(input int ctl, input bit mask, input int a, input int b,
                                        input bit ci, input bit vi, input bit ni, input bit zi);
    int r, s, ss, t;
    bit c, v, n, z, nz;
    logic [7:0] rb;
    c = ci; v = vi; n = ni; z = zi; r = a; nz = 1'b0;
    case (ctl)
      1:  begin r = a | b; nz = 1; end
      2:  begin r = a & b; nz = 1; end
      3:  begin r = a ^ b; nz = 1; end
      4:  begin
            s = a + b + int'(ci); r = s % 256; c = (s > 255);
            ss = sx(a) + sx(b) + int'(ci); v = (ss > 127) || (ss < -128); nz = 1;
          end
      5:  begin
            s = a - b - (ci ? 0 : 1); c = (s >= 0); r = (s + 256) % 256;
            ss = sx(a) - sx(b) - (ci ? 0 : 1); v = (ss > 127) || (ss < -128); nz = 1;
          end
      6:  begin t = (a - b + 256) % 256; c = (a >= b); n = (t >= 128); z = (t == 0); end
      7:  begin z = ((a & b) == 0); n = (b >= 128); v = ((b & 64) != 0); end
      8:  begin r = (a * 2) % 256; c = (a >= 128); nz = 1; end
      9:  begin r = a / 2; c = (a % 2) == 1; nz = 1; end
      10: begin r = (a * 2) % 256 + int'(ci); c = (a >= 128); nz = 1; end
      11: begin r = a / 2 + (ci ? 128 : 0); c = (a % 2) == 1; nz = 1; end
      12: begin r = (a + 1) % 256; nz = 1; end
      13: begin r = (a + 255) % 256; nz = 1; end
      14: begin r = b; nz = 1; end
      15: c = 0;
      16: c = 1;
      17: v = 0;
      default: r = a;
    endcase
    if (nz) begin n = (r >= 128); z = (r == 0); end
    if (!mask) begin c = ci; v = vi; n = ni; z = zi; end
    rb = 8'(r);
    return {rb, n, v, z, c};
  endfunction

  // ---------------- driver ----------------
  task automatic step(input bit rst, input bit en, input int ctl, input bit mask,
                      input int a, input int b, input bit ci, input bit vi,
                      input bit ni, input bit zi, input string tag);
    logic [4:0] code;
    code       = 5'(ctl);
    I_reset    = rst;
    I_enable   = en;
    I_control  = control_type'(code);
    I_mask_p   = mask;
    I_lhs      = 8'(a);
    I_rhs      = 8'(b);
    I_carry    = ci;
    I_overflow = vi;
    I_sign     = ni;
    I_zero     = zi;
    if (rst) exp_state = 12'h000;
    else if (en) exp_state = model(ctl, mask, a, b, ci, vi, ni, zi);
    exp_q.push_back(exp_state);
    @(posedge I_clock);
    #1;
    check(tag, observed(), exp_q.pop_front());
  endtask

  // Literal expectation taken straight from the operation definitions.
  task automatic expect_out(input string tag, input logic [7:0] res,
                            input bit n, input bit v, input bit z, input bit c);
    check(tag, observed(), {res, n, v, z, c});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_checks = 0;
    n_passed = 0;
    exp_state = 12'h000;
    I_reset = 1'b1; I_enable = 1'b0; I_control = control_nop; I_mask_p = 1'b0;
    I_lhs = 8'h00; I_rhs = 8'h00;
    I_carry = 1'b0; I_overflow = 1'b0; I_sign = 1'b0; I_zero = 1'b0;
    @(negedge I_clock);

    // Reset asserted with enable high and a live operation.
    step(1, 1, 4, 1, 8'h55, 8'h66, 1, 1, 1, 1, "reset");
    expect_out("reset_lit", 8'h00, 0, 0, 0, 0);

    // step args: rst, en, ctl, mask, lhs, rhs, C, V, N, Z
    step(0, 1, 4, 1, 8'h50, 8'h50, 0, 0, 0, 0, "adc_50_50");
    expect_out("adc_50_50_lit", 8'hA0, 1, 1, 0, 0);
    step(0, 1, 4, 1, 8'hFF, 8'h01, 0, 0, 0, 0, "adc_ff_01");
    expect_out("adc_ff_01_lit", 8'h00, 0, 0, 1, 1);
    step(0, 1, 5, 1, 8'h00, 8'h01, 1, 0, 0, 0, "sbc_00_01");
    expect_out("sbc_00_01_lit", 8'hFF, 1, 0, 0, 0);
    step(0, 1, 5, 1, 8'h80, 8'h01, 1, 0, 0, 0, "sbc_80_01");
    expect_out("sbc_80_01_lit", 8'h7F, 0, 1, 0, 1);
    step(0, 1, 6, 1, 8'h40, 8'h40, 0, 1, 0, 0, "cmp_eq");
    expect_out("cmp_eq_lit", 8'h40, 0, 1, 1, 1);
    step(0, 1, 6, 1, 8'h10, 8'h20, 1, 0, 0, 1, "cmp_lt");
    expect_out("cmp_lt_lit", 8'h10, 1, 0, 0, 0);
    step(0, 1, 11, 1, 8'h01, 8'h00, 1, 0, 0, 0, "ror_01");
    expect_out("ror_01_lit", 8'h80, 1, 0, 0, 1);
    step(0, 1, 8, 1, 8'h80, 8'h00, 0, 0, 0, 0, "asl_80");
    expect_out("asl_80_lit", 8'h00, 0, 0, 1, 1);
    step(0, 1, 12, 1, 8'hFF, 8'h00, 0, 0, 0, 0, "inc_ff");
    expect_out("inc_ff_lit", 8'h00, 0, 0, 1, 0);
    step(0, 1, 13, 1, 8'h00, 8'h00, 1, 0, 0, 0, "dec_00");
    expect_out("dec_00_lit", 8'hFF, 1, 0, 0, 1);
    step(0, 1, 7, 1, 8'h0F, 8'hC0, 1, 0, 0, 0, "bit_0f_c0");
    expect_out("bit_0f_c0_lit", 8'h0F, 1, 1, 1, 1);
    step(0, 1, 17, 1, 8'h33, 8'h00, 1, 1, 1, 0, "clv");
    expect_out("clv_lit", 8'h33, 1, 0, 0, 1);
    step(0, 1, 25, 1, 8'h5A, 8'hA5, 0, 1, 0, 1, "reserved");
    expect_out("reserved_lit", 8'h5A, 0, 1, 1, 0);
    step(0, 1, 4, 0, 8'h10, 8'h20, 1, 0, 0, 1, "adc_masked");
    expect_out("adc_masked_lit", 8'h31, 0, 0, 1, 1);
    step(0, 0, 14, 1, 8'h00, 8'h80, 0, 1, 1, 0, "hold");
    expect_out("hold_lit", 8'h31, 0, 0, 1, 1);
    step(1, 0, 14, 1, 8'h00, 8'h80, 0, 1, 1, 0, "reset_mid");
    expect_out("reset_mid_lit", 8'h00, 0, 0, 0, 0);

    // Randomized traffic: every code including reserved, occasional hold and reset.
    for (int k = 0; k < 400; k++) begin
      step($urandom_range(0, 39) == 0, $urandom_range(0, 5) != 0,
           int'($urandom_range(0, 31)), $urandom_range(0, 4) != 0,
           int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
           1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), "rand");
    end

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule
